// File: rtl/axis_plasticity_scheduler.sv
// Queued plasticity job scheduler: buffers range-limited jobs and sequences an external row engine.
// Define PLASTICITY_STATS_EN to enable the o_job_count / o_drop_count counters (tied to 0 otherwise).
module axis_plasticity_scheduler #(
    parameter int DIM        = 16384,
    parameter int N_LAYERS   = 512,
    parameter int CHUNK_BITS = 512,
    parameter int QDEPTH     = 4,
    parameter int TAG_W      = 4,
    parameter int LW         = $clog2(N_LAYERS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [7:0]       i_req_reward,
    input  logic [DIM-1:0]   i_req_context,
    input  logic [LW-1:0]    i_req_layer_lo,
    input  logic [LW-1:0]    i_req_layer_hi,
    input  logic [TAG_W-1:0] i_req_tag,
    input  logic             i_abort,
    output logic             o_row_start,
    output logic [7:0]       o_row_reward,
    output logic [DIM-1:0]   o_row_context,
    output logic [31:0]      o_row_base,
    input  logic             i_row_done,
    output logic             o_busy,
    output logic             o_done,
    output logic [TAG_W-1:0] o_done_tag,
    output logic             o_done_aborted,
    output logic             o_err,
    output logic [31:0]      o_job_count,
    output logic [31:0]      o_drop_count
);
    // state      | meaning
    // S_IDLE     | waiting for a queued job
    // S_POP      | latch job fields from FIFO head and pop it
    // S_START    | o_row_start high for the current layer
    // S_WAIT     | row engine busy, waiting for i_row_done
    // S_NEXT     | advance layer or finish (last layer or abort)
    // S_COMPLETE | o_done high, job result published

    localparam int NUM_CHUNKS = DIM / CHUNK_BITS;
    localparam int AW         = $clog2(QDEPTH);
    localparam int LW_Q       = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_START, S_WAIT, S_NEXT, S_COMPLETE
    } state_t;

    logic [7:0]       fifo_reward_mem [QDEPTH];
    logic [DIM-1:0]   fifo_ctx_mem    [QDEPTH];
    logic [LW-1:0]    fifo_lo_mem     [QDEPTH];
    logic [LW-1:0]    fifo_hi_mem     [QDEPTH];
    logic [TAG_W-1:0] fifo_tag_mem    [QDEPTH];

    logic [LW_Q-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LW_Q-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW_Q-1:0]  count_d;
    logic             ready_q, ready_d;
    logic             fifo_empty;
    logic [AW-1:0]    wr_idx, rd_idx;

    state_t           state_q, state_d;
    logic [LW-1:0]    layer_q, layer_d;
    logic [LW-1:0]    hi_q, hi_d;
    logic [7:0]       reward_q, reward_d;
    logic [DIM-1:0]   ctx_q, ctx_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             abort_q, abort_d;
    logic             busy_q, busy_d;
    logic             row_start_q, row_start_d;
    logic [31:0]      row_base_q, row_base_d;
    logic             done_q, done_d;
    logic [TAG_W-1:0] done_tag_q, done_tag_d;
    logic             done_aborted_q, done_aborted_d;
    logic             err_q, err_d;

    logic             req_fire, range_bad, push, pop;

    assign req_fire  = i_req_valid && ready_q;
    assign range_bad = (i_req_layer_lo > i_req_layer_hi) ||
                       (32'(i_req_layer_hi) >= 32'(N_LAYERS));
    assign push      = req_fire && !range_bad && (i_req_reward != 8'd0);
    assign pop       = (state_q == S_POP);

    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);

    // Ready is registered so it reads 0 in reset and rises one cycle after release.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(LW_Q-1){1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{(LW_Q-1){1'b0}}, pop};
        count_d  = wr_ptr_d - rd_ptr_d;
        ready_d  = (count_d != LW_Q'(QDEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reward_mem[wr_idx] <= i_req_reward;
            fifo_ctx_mem[wr_idx]    <= i_req_context;
            fifo_lo_mem[wr_idx]     <= i_req_layer_lo;
            fifo_hi_mem[wr_idx]     <= i_req_layer_hi;
            fifo_tag_mem[wr_idx]    <= i_req_tag;
        end
    end

    always_comb begin
        state_d        = state_q;
        layer_d        = layer_q;
        hi_d           = hi_q;
        reward_d       = reward_q;
        ctx_d          = ctx_q;
        tag_d          = tag_q;
        abort_d        = abort_q;
        busy_d         = busy_q;
        row_start_d    = 1'b0;
        done_d         = 1'b0;
        done_tag_d     = done_tag_q;
        done_aborted_d = done_aborted_q;
        err_d          = req_fire && range_bad;

        if (i_abort && (state_q inside {S_POP, S_START, S_WAIT, S_NEXT}))
            abort_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_POP;
                    busy_d  = 1'b1;
                end
            end
            S_POP: begin
                reward_d    = fifo_reward_mem[rd_idx];
                ctx_d       = fifo_ctx_mem[rd_idx];
                layer_d     = fifo_lo_mem[rd_idx];
                hi_d        = fifo_hi_mem[rd_idx];
                tag_d       = fifo_tag_mem[rd_idx];
                row_start_d = 1'b1;
                state_d     = S_START;
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (i_row_done)
                    state_d = S_NEXT;
            end
            S_NEXT: begin
                // An abort arriving in this very cycle already suppresses the next row.
                if ((layer_q == hi_q) || abort_q || i_abort) begin
                    state_d        = S_COMPLETE;
                    done_d         = 1'b1;
                    done_tag_d     = tag_q;
                    done_aborted_d = abort_q || i_abort;
                    abort_d        = 1'b0;
                    busy_d         = 1'b0;
                end else begin
                    layer_d     = layer_q + LW'(1);
                    row_start_d = 1'b1;
                    state_d     = S_START;
                end
            end
            S_COMPLETE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        row_base_d = 32'(layer_d) * 32'(NUM_CHUNKS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            ready_q        <= 1'b0;
            layer_q        <= '0;
            hi_q           <= '0;
            reward_q       <= '0;
            ctx_q          <= '0;
            tag_q          <= '0;
            abort_q        <= 1'b0;
            busy_q         <= 1'b0;
            row_start_q    <= 1'b0;
            row_base_q     <= '0;
            done_q         <= 1'b0;
            done_tag_q     <= '0;
            done_aborted_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            ready_q        <= ready_d;
            layer_q        <= layer_d;
            hi_q           <= hi_d;
            reward_q       <= reward_d;
            ctx_q          <= ctx_d;
            tag_q          <= tag_d;
            abort_q        <= abort_d;
            busy_q         <= busy_d;
            row_start_q    <= row_start_d;
            row_base_q     <= row_base_d;
            done_q         <= done_d;
            done_tag_q     <= done_tag_d;
            done_aborted_q <= done_aborted_d;
            err_q          <= err_d;
        end
    end

`ifdef PLASTICITY_STATS_EN
    logic [31:0] job_count_q, job_count_d;
    logic [31:0] drop_count_q, drop_count_d;
    logic        drop;

    assign drop = req_fire && !range_bad && (i_req_reward == 8'd0);

    always_comb begin
        job_count_d  = job_count_q + {31'b0, done_d};
        drop_count_d = drop_count_q + {31'b0, drop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            job_count_q  <= job_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign o_job_count  = job_count_q;
    assign o_drop_count = drop_count_q;
`else
    assign o_job_count  = 32'd0;
    assign o_drop_count = 32'd0;
`endif

    assign o_req_ready    = ready_q;
    assign o_row_start    = row_start_q;
    assign o_row_reward   = reward_q;
    assign o_row_context  = ctx_q;
    assign o_row_base     = row_base_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_done_tag     = done_tag_q;
    assign o_done_aborted = done_aborted_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_axis_plasticity_scheduler.sv
// Scoreboard bench for axis_plasticity_scheduler: expected rows/completions queued at stimulus,
// checked when the DUT emits o_row_start / o_done. Engine is a simple latency model.
module tb_axis_plasticity_scheduler;
    localparam int DIM        = 16384;
    localparam int N_LAYERS   = 512;
    localparam int CHUNK_BITS = 512;
    localparam int QDEPTH     = 4;
    localparam int TAG_W      = 4;
    localparam int LW         = 9;
    localparam int NCH        = DIM / CHUNK_BITS;
`ifdef PLASTICITY_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk, rst_n;
    logic             i_req_valid, o_req_ready;
    logic [7:0]       i_req_reward;
    logic [DIM-1:0]   i_req_context;
    logic [LW-1:0]    i_req_layer_lo, i_req_layer_hi;
    logic [TAG_W-1:0] i_req_tag;
    logic             i_abort;
    logic             o_row_start;
    logic [7:0]       o_row_reward;
    logic [DIM-1:0]   o_row_context;
    logic [31:0]      o_row_base;
    logic             i_row_done;
    logic             o_busy, o_done;
    logic [TAG_W-1:0] o_done_tag;
    logic             o_done_aborted, o_err;
    logic [31:0]      o_job_count, o_drop_count;

    axis_plasticity_scheduler #(
        .DIM(DIM), .N_LAYERS(N_LAYERS), .CHUNK_BITS(CHUNK_BITS),
        .QDEPTH(QDEPTH), .TAG_W(TAG_W), .LW(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_reward(i_req_reward), .i_req_context(i_req_context),
        .i_req_layer_lo(i_req_layer_lo), .i_req_layer_hi(i_req_layer_hi),
        .i_req_tag(i_req_tag), .i_abort(i_abort),
        .o_row_start(o_row_start), .o_row_reward(o_row_reward),
        .o_row_context(o_row_context), .o_row_base(o_row_base),
        .i_row_done(i_row_done), .o_busy(o_busy), .o_done(o_done),
        .o_done_tag(o_done_tag), .o_done_aborted(o_done_aborted),
        .o_err(o_err), .o_job_count(o_job_count), .o_drop_count(o_drop_count)
    );

    typedef struct {
        logic [31:0]    base;
        logic [7:0]     reward;
        logic [DIM-1:0] ctx;
    } row_t;
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             aborted;
    } done_t;

    row_t  exp_rows[$];
    done_t exp_dones[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    row_starts = 0;
    int    last_rd_cyc = 0;
    int    exp_jobs = 0;
    int    exp_drops = 0;
    int    eng_lat = 10;
    bit    eng_stall = 1'b0;

    function automatic logic [31:0] stat_exp(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Row-engine model: i_row_done eng_lat cycles after each start, frozen while stalled.
    initial begin : engine
        int  cnt;
        bit  pend;
        pend = 1'b0;
        cnt = 0;
        i_row_done = 1'b0;
        forever begin
            @(negedge clk);
            i_row_done = 1'b0;
            if (!rst_n) pend = 1'b0;
            else if (o_row_start) begin
                pend = 1'b1;
                cnt = eng_lat;
            end else if (pend && !eng_stall) begin
                if (cnt > 1) cnt--;
                else begin
                    i_row_done = 1'b1;
                    pend = 1'b0;
                    last_rd_cyc = cyc;
                end
            end
        end
    end

    initial begin : monitor
        row_t  er;
        done_t ed;
        forever begin
            @(negedge clk);
            if (rst_n && o_row_start) begin
                row_starts++;
                n_checks++;
                if (exp_rows.size() == 0) begin
                    n_fail++;
                    $display("FAIL row_start_unexpected: got base=%0d, required no start", o_row_base);
                end else begin
                    er = exp_rows.pop_front();
                    if (o_row_base !== er.base || o_row_reward !== er.reward || o_row_context !== er.ctx) begin
                        n_fail++;
                        $display("FAIL row_start: got base=%0d reward=%0d ctx_ok=%0b, required base=%0d reward=%0d",
                                 o_row_base, o_row_reward, o_row_context === er.ctx, er.base, er.reward);
                    end
                end
            end
            if (rst_n && o_done) begin
                n_checks++;
                if (exp_dones.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: got tag=%0d, required no done", o_done_tag);
                end else begin
                    ed = exp_dones.pop_front();
                    exp_jobs++;
                    if (o_done_tag !== ed.tag || o_done_aborted !== ed.aborted || o_job_count !== stat_exp(exp_jobs)) begin
                        n_fail++;
                        $display("FAIL done: got tag=%0d aborted=%0b jobs=%0d, required tag=%0d aborted=%0b jobs=%0d",
                                 o_done_tag, o_done_aborted, o_job_count, ed.tag, ed.aborted, stat_exp(exp_jobs));
                    end
                end
                n_checks++;
                if (cyc - last_rd_cyc !== 2) begin
                    n_fail++;
                    $display("FAIL done_latency: got %0d cycles, required 2", cyc - last_rd_cyc);
                end
            end
        end
    end

    // Presents one request (valid left high); pushes expectations unless it should be rejected/dropped.
    task automatic send(input logic [7:0] rw, input logic [LW-1:0] lo, input logic [LW-1:0] hi,
                        input logic [TAG_W-1:0] tag, input int n_rows, input bit aborted,
                        output int waited);
        logic [DIM-1:0] ctx;
        row_t           r;
        done_t          d;
        int             n;
        for (int i = 0; i < DIM / 32; i++) ctx[i*32 +: 32] = $urandom;
        if (lo <= hi && rw != 8'd0) begin
            n = (n_rows < 0) ? (int'(hi) - int'(lo) + 1) : n_rows;
            for (int k = 0; k < n; k++) begin
                r.base = 32'((int'(lo) + k) * NCH);
                r.reward = rw;
                r.ctx = ctx;
                exp_rows.push_back(r);
            end
            d.tag = tag;
            d.aborted = aborted;
            exp_dones.push_back(d);
        end
        @(negedge clk);
        i_req_reward = rw;
        i_req_context = ctx;
        i_req_layer_lo = lo;
        i_req_layer_hi = hi;
        i_req_tag = tag;
        i_req_valid = 1'b1;
        waited = 0;
        while (!o_req_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: ready stayed low, required accept within 2000 cycles");
        end
        @(posedge clk);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((exp_rows.size() != 0 || exp_dones.size() != 0 || o_busy) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (w >= 20000) begin
            n_fail++;
            $display("FAIL wait_idle: rows_left=%0d dones_left=%0d busy=%0b, required all drained",
                     exp_rows.size(), exp_dones.size(), o_busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (o_req_ready !== 1'b0 || o_busy !== 1'b0 || o_row_start !== 1'b0 || o_done !== 1'b0 ||
            o_err !== 1'b0 || o_row_base !== 32'd0 || o_done_tag !== '0 || o_done_aborted !== 1'b0 ||
            o_job_count !== 32'd0 || o_drop_count !== 32'd0 || o_row_reward !== 8'd0) begin
            n_fail++;
            $display("FAIL %s: got ready=%0b busy=%0b start=%0b done=%0b err=%0b base=%0d tag=%0d jobs=%0d, required all 0",
                     name, o_req_ready, o_busy, o_row_start, o_done, o_err, o_row_base, o_done_tag, o_job_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %0b, required 1", o_req_ready);
        end
    endtask

    task automatic test_single_job();
        int w, lat;
        eng_lat = 10;
        send(8'sd5, 9'd3, 9'd5, 4'd7, -1, 1'b0, w);
        drop_valid();
        lat = 1;
        while (!o_row_start && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL accept_to_start: got %0d cycles, required 3", lat);
        end
        wait_idle();
        n_checks++;
        if (o_done_tag !== 4'd7 || o_done_aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold: got tag=%0d aborted=%0b, required tag=7 aborted=0", o_done_tag, o_done_aborted);
        end
    endtask

    task automatic test_fill();
        int w;
        eng_stall = 1'b1;
        eng_lat = 2;
        for (int i = 0; i < 5; i++) begin
            send(8'(10 + i), 9'(20 + i), 9'(20 + i), 4'(i + 1), -1, 1'b0, w);
            n_checks++;
            if (w !== 0) begin
                n_fail++;
                $display("FAIL fill_ready_%0d: waited %0d cycles, required 0", i, w);
            end
        end
        @(negedge clk);
        i_req_tag = 4'd6;
        n_checks++;
        if (o_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got ready=%0b, required 0", o_req_ready);
        end
        i_req_valid = 1'b0;
        repeat (5) @(negedge clk);
        eng_stall = 1'b0;
        wait_idle();
    endtask

    task automatic test_zero_reward();
        int w;
        send(8'd0, 9'd1, 9'd2, 4'd9, -1, 1'b0, w);
        drop_valid();
        exp_drops++;
        n_checks++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reward_err: got %0b, required 0", o_err);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (o_drop_count !== stat_exp(exp_drops) || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reward_drop: got drops=%0d busy=%0b, required drops=%0d busy=0",
                     o_drop_count, o_busy, stat_exp(exp_drops));
        end
    endtask

    task automatic test_bad_range();
        int w;
        send(8'sd20, 9'd10, 9'd9, 4'd2, -1, 1'b0, w);
        drop_valid();
        n_checks++;
        if (o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_range_err: got %0b, required 1", o_err);
        end
        @(negedge clk);
        n_checks++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_range_pulse: got %0b, required 0", o_err);
        end
        eng_lat = 1;
        send(8'sd20, 9'd0, 9'd511, 4'd3, -1, 1'b0, w);
        drop_valid();
        n_checks++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_range_err: got %0b, required 0", o_err);
        end
        wait_idle();
        n_checks++;
        if (o_drop_count !== stat_exp(exp_drops)) begin
            n_fail++;
            $display("FAIL bad_range_drops: got %0d, required %0d", o_drop_count, stat_exp(exp_drops));
        end
    endtask

    task automatic test_abort();
        int w, base_rs;
        eng_lat = 10;
        base_rs = row_starts;
        send(8'hF9, 9'd0, 9'd511, 4'd3, 3, 1'b1, w);
        send(8'sd9, 9'd5, 9'd6, 4'd4, -1, 1'b0, w);
        drop_valid();
        w = 0;
        while (row_starts < base_rs + 3 && w < 500) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (w >= 500) begin
            n_fail++;
            $display("FAIL abort_wait: got %0d starts, required 3", row_starts - base_rs);
        end
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        wait_idle();
    endtask

    task automatic test_abort_idle();
        int w;
        eng_lat = 3;
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        send(8'sd3, 9'd1, 9'd2, 4'd5, -1, 1'b0, w);
        drop_valid();
        wait_idle();
    endtask

    task automatic test_reset_mid_job();
        int w, base_rs;
        eng_lat = 10;
        base_rs = row_starts;
        send(8'sd4, 9'd0, 9'd3, 4'd8, -1, 1'b0, w);
        send(8'sd6, 9'd0, 9'd1, 4'd9, -1, 1'b0, w);
        drop_valid();
        w = 0;
        while (row_starts < base_rs + 1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_rows.delete();
        exp_dones.delete();
        exp_jobs = 0;
        exp_drops = 0;
        check_reset_outputs("mid_job_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || o_req_ready !== 1'b1 || o_job_count !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%0b ready=%0b jobs=%0d, required busy=0 ready=1 jobs=0",
                     o_busy, o_req_ready, o_job_count);
        end
        send(8'sd2, 9'd7, 9'd8, 4'd10, -1, 1'b0, w);
        drop_valid();
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        i_req_valid = 1'b0;
        i_req_reward = '0;
        i_req_context = '0;
        i_req_layer_lo = '0;
        i_req_layer_hi = '0;
        i_req_tag = '0;
        i_abort = 1'b0;
        test_reset();
        test_single_job();
        test_fill();
        test_zero_reward();
        test_bad_range();
        test_abort();
        test_abort_idle();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
